// File: rtl/s3_writeback_regfile_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared constants and types for the writeback stage and its register file.
//   DATA_WIDTH    : width of a register / ALU result
//   ADDR_WIDTH    : register select width (depth = 2**ADDR_WIDTH)
//   ZERO_REG_ADDR : address of the hardwired-zero register
//   wb_bundle_t   : ALUOut / WriteSelect / WriteEnable bundle passed stage to stage
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 5;
  localparam int unsigned ZERO_REG_ADDR = 0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] ALUOut;
    logic [ADDR_WIDTH-1:0] WriteSelect;
    logic                  WriteEnable;
  } wb_bundle_t;

endpackage : pipeline_pkg

// File: rtl/s3_writeback_regfile_if.sv
// -----------------------------------------------------------------------------
// s3_writeback_regfile_if
// Bus between the pipeline and the writeback stage / register file.
//   S2_ALUOut, S2_WriteSelect, S2_WriteEnable : execute-stage result into stage 3
//   S1_ReadSelect1, S1_ReadSelect2            : read port addresses
//   Reg_ReadData1, Reg_ReadData2              : read port data (combinational)
//   S3_ALUOut, S3_WriteSelect, S3_WriteEnable : registered stage-3 bundle
// master : the pipeline side (drives S2_* and S1_*)
// slave  : the writeback/regfile block
// -----------------------------------------------------------------------------
interface s3_writeback_regfile_if #(
  parameter int unsigned DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] S2_ALUOut;
  logic [ADDR_WIDTH-1:0] S2_WriteSelect;
  logic                  S2_WriteEnable;
  logic [ADDR_WIDTH-1:0] S1_ReadSelect1;
  logic [ADDR_WIDTH-1:0] S1_ReadSelect2;
  logic [DATA_WIDTH-1:0] Reg_ReadData1;
  logic [DATA_WIDTH-1:0] Reg_ReadData2;
  logic [DATA_WIDTH-1:0] S3_ALUOut;
  logic [ADDR_WIDTH-1:0] S3_WriteSelect;
  logic                  S3_WriteEnable;

  modport master (
    output S2_ALUOut, S2_WriteSelect, S2_WriteEnable,
    output S1_ReadSelect1, S1_ReadSelect2,
    input  Reg_ReadData1, Reg_ReadData2,
    input  S3_ALUOut, S3_WriteSelect, S3_WriteEnable
  );

  modport slave (
    input  S2_ALUOut, S2_WriteSelect, S2_WriteEnable,
    input  S1_ReadSelect1, S1_ReadSelect2,
    output Reg_ReadData1, Reg_ReadData2,
    output S3_ALUOut, S3_WriteSelect, S3_WriteEnable
  );

endinterface : s3_writeback_regfile_if

// File: rtl/s3_writeback_regfile_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Register file with one synchronous write port and two combinational reads.
//   i_clk              : clock, posedge
//   i_rst_n            : synchronous active-low reset, clears every entry
//   i_we/i_waddr/i_wdata : write port
//   i_raddr1/i_raddr2  : read addresses
//   o_rdata1/o_rdata2  : read data
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (write-before-read forwarding).
// -----------------------------------------------------------------------------
module regfile_2r1w
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2
);

  localparam int unsigned            DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR  = ADDR_WIDTH'(ZERO_REG_ADDR);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rdata1;
  logic [DATA_WIDTH-1:0] w_rdata2;

  // Writes to the hardwired-zero register are dropped at the storage.
  assign w_wr_ok = i_we && !(ZERO_REG && (i_waddr == ZADDR));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    w_rdata1 = r_mem[i_raddr1];
    w_rdata2 = r_mem[i_raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (i_we && (i_waddr == i_raddr1)) w_rdata1 = i_wdata;
    if (i_we && (i_waddr == i_raddr2)) w_rdata2 = i_wdata;
`endif
    // Zero override comes last so it also masks any bypass.
    if (ZERO_REG && (i_raddr1 == ZADDR)) w_rdata1 = '0;
    if (ZERO_REG && (i_raddr2 == ZADDR)) w_rdata2 = '0;
  end

  assign o_rdata1 = w_rdata1;
  assign o_rdata2 = w_rdata2;

endmodule : regfile_2r1w

// File: rtl/s3_writeback_regfile.sv
// -----------------------------------------------------------------------------
// s3_writeback_regfile
// Stage-3 (writeback) pipeline register feeding a 2-read/1-write register file.
// S2 bundle is latched into S3 on every non-reset edge; S3 commits to the
// register file on the following edge.
//   clk : clock, posedge
//   rst : synchronous active-low reset (0 = reset)
//   bus : s3_writeback_regfile_if.slave (S2_*, S1_* in; Reg_ReadData*, S3_* out)
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (read ports forward S3_ALUOut).
// -----------------------------------------------------------------------------
module s3_writeback_regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  s3_writeback_regfile_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_s3_aluout;
  logic [ADDR_WIDTH-1:0] r_s3_wsel;
  logic                  r_s3_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s3_aluout <= '0;
      r_s3_wsel   <= '0;
      r_s3_we     <= 1'b0;
    end else begin
      r_s3_aluout <= bus.S2_ALUOut;
      r_s3_wsel   <= bus.S2_WriteSelect;
      r_s3_we     <= bus.S2_WriteEnable;
    end
  end

  regfile_2r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_regfile (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_we     (r_s3_we),
    .i_waddr  (r_s3_wsel),
    .i_wdata  (r_s3_aluout),
    .i_raddr1 (bus.S1_ReadSelect1),
    .i_raddr2 (bus.S1_ReadSelect2),
    .o_rdata1 (bus.Reg_ReadData1),
    .o_rdata2 (bus.Reg_ReadData2)
  );

  assign bus.S3_ALUOut      = r_s3_aluout;
  assign bus.S3_WriteSelect = r_s3_wsel;
  assign bus.S3_WriteEnable = r_s3_we;

endmodule : s3_writeback_regfile

// File: tb/tb_s3_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_s3_writeback_regfile
// Drives two instances (ZERO_REG=1 and ZERO_REG=0) with identical stimulus and
// compares both against an array-based model of the architectural state plus
// one in-flight stage-3 bundle.
// -----------------------------------------------------------------------------
module tb_s3_writeback_regfile;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d_alu;
  logic [4:0]  d_sel;
  logic        d_we;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;

  s3_writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
  s3_writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();

  assign bus1.S2_ALUOut      = d_alu;
  assign bus1.S2_WriteSelect = d_sel;
  assign bus1.S2_WriteEnable = d_we;
  assign bus1.S1_ReadSelect1 = d_rs1;
  assign bus1.S1_ReadSelect2 = d_rs2;
  assign bus0.S2_ALUOut      = d_alu;
  assign bus0.S2_WriteSelect = d_sel;
  assign bus0.S2_WriteEnable = d_we;
  assign bus0.S1_ReadSelect1 = d_rs1;
  assign bus0.S1_ReadSelect2 = d_rs2;

  s3_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  s3_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  // Reference model: architectural contents per variant, plus the bundle in S3.
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  wb_bundle_t  m_s3;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input bit zr, input logic [4:0] a);
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (m_s3.WriteEnable && m_s3.WriteSelect == a) return m_s3.ALUOut;
`endif
    return zr ? m1[a] : m0[a];
  endfunction

  // One clock edge: advance model with the values that were present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m1[i] = 32'h0;
        m0[i] = 32'h0;
      end
      m_s3 = '0;
    end else begin
      if (m_s3.WriteEnable) begin
        m0[m_s3.WriteSelect] = m_s3.ALUOut;
        if (m_s3.WriteSelect != 5'd0) m1[m_s3.WriteSelect] = m_s3.ALUOut;
      end
      m_s3.ALUOut      = d_alu;
      m_s3.WriteSelect = d_sel;
      m_s3.WriteEnable = d_we;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] sel, input logic [31:0] alu);
    d_we = we; d_sel = sel; d_alu = alu;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    d_rs1 = a1; d_rs2 = a2;
    #1;
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".s3_alu"}, bus1.S3_ALUOut, m_s3.ALUOut);
    cmp({tag, ".s3_sel"}, {27'd0, bus1.S3_WriteSelect}, {27'd0, m_s3.WriteSelect});
    cmp({tag, ".s3_we"},  {31'd0, bus1.S3_WriteEnable}, {31'd0, m_s3.WriteEnable});
    cmp({tag, ".z1.rd1"}, bus1.Reg_ReadData1, exp_read(1'b1, d_rs1));
    cmp({tag, ".z1.rd2"}, bus1.Reg_ReadData2, exp_read(1'b1, d_rs2));
    cmp({tag, ".z0.rd1"}, bus0.Reg_ReadData1, exp_read(1'b0, d_rs1));
    cmp({tag, ".z0.rd2"}, bus0.Reg_ReadData2, exp_read(1'b0, d_rs2));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m1[i] = 32'h0;
      m0[i] = 32'h0;
    end
    m_s3 = '0;
    drive(1'b0, 5'd0, 32'h0);
    d_rs1 = 5'd0; d_rs2 = 5'd0;

    // Initial reset, then arbitrary writes, then reset for 2 cycles.
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), $urandom);
      tick();
      set_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      check_all("prewrite");
    end
    rst = 1'b0;
    tick(); tick();
    cmp("rst.s3_alu", bus1.S3_ALUOut, 32'h0);
    cmp("rst.s3_we", {31'd0, bus1.S3_WriteEnable}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      set_reads(5'(a), 5'(31 - a));
      cmp("rst.z1.rd1", bus1.Reg_ReadData1, 32'h0);
      cmp("rst.z0.rd2", bus0.Reg_ReadData2, 32'h0);
      check_all("rst");
    end
    rst = 1'b1;

    // Basic write: visible after the second edge (bypass-dependent in between).
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    set_reads(5'd5, 5'd5);
    tick();
    drive(1'b0, 5'd0, 32'h0);
    cmp("basic.s3_alu", bus1.S3_ALUOut, 32'hDEADBEEF);
`ifdef REGFILE_WRITE_BYPASS_EN
    cmp("basic.edge1.rd1", bus1.Reg_ReadData1, 32'hDEADBEEF);
`else
    cmp("basic.edge1.rd1", bus1.Reg_ReadData1, 32'h0);
`endif
    check_all("basic.e1");
    tick();
    cmp("basic.edge2.rd1", bus1.Reg_ReadData1, 32'hDEADBEEF);
    check_all("basic.e2");

    // Bypass: S3 holds sel=9 data=A5A5A5A5, both ports address 9.
    drive(1'b1, 5'd9, 32'hA5A5A5A5);
    set_reads(5'd9, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0);
`ifdef REGFILE_WRITE_BYPASS_EN
    cmp("byp.rd1", bus1.Reg_ReadData1, 32'hA5A5A5A5);
    cmp("byp.rd2", bus1.Reg_ReadData2, 32'hA5A5A5A5);
`else
    cmp("byp.rd1", bus1.Reg_ReadData1, 32'h0);
    cmp("byp.rd2", bus1.Reg_ReadData2, 32'h0);
`endif
    check_all("byp.e1");
    tick();
    cmp("byp.after.rd2", bus1.Reg_ReadData2, 32'hA5A5A5A5);
    check_all("byp.e2");

    // Zero register.
    drive(1'b1, 5'd0, 32'h12345678);
    set_reads(5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0);
    check_all("zero.e1");
    tick();
    cmp("zero.z1.rd1", bus1.Reg_ReadData1, 32'h0);
    cmp("zero.z0.rd1", bus0.Reg_ReadData1, 32'h12345678);
    check_all("zero.e2");

    // Enable low: register 7 keeps 0x11.
    drive(1'b1, 5'd7, 32'h00000011);
    tick();
    drive(1'b0, 5'd7, 32'hFFFFFFFF);
    tick();
    tick();
    drive(1'b0, 5'd0, 32'h0);
    tick();
    set_reads(5'd7, 5'd7);
    cmp("enlow.rd1", bus1.Reg_ReadData1, 32'h00000011);
    check_all("enlow");

    // Back-to-back writes to the same register: last one wins.
    drive(1'b1, 5'd12, 32'h00000001); tick();
    drive(1'b1, 5'd12, 32'h00000002); tick();
    drive(1'b1, 5'd12, 32'h00000003); tick();
    drive(1'b0, 5'd0, 32'h0); tick();
    set_reads(5'd12, 5'd12);
    cmp("b2b.rd2", bus1.Reg_ReadData2, 32'h00000003);
    check_all("b2b");

    // Reset on the commit edge discards the in-flight write to register 3.
    drive(1'b1, 5'd3, 32'hCAFEF00D);
    tick();
    drive(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_reads(5'd3, 5'd3);
    cmp("midrst.rd1", bus1.Reg_ReadData1, 32'h0);
    cmp("midrst.s3_we", {31'd0, bus1.S3_WriteEnable}, 32'h0);
    check_all("midrst");

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) != 0);
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
            $urandom);
      tick();
      if ($urandom_range(0, 1) != 0)
        set_reads(m_s3.WriteSelect, 5'($urandom_range(0, 31)));
      else
        set_reads(5'($urandom_range(0, 3)), m_s3.WriteSelect);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_s3_writeback_regfile

// File: doc/s3_writeback_regfile.md
Name: s3_writeback_regfile

Overview:
- Writer end of the operand path that the stage-2 pipeline register reads from.
- Latches the execute-stage result into the stage-3 (writeback) pipeline register, then commits it to a 32-entry register file.
- Two asynchronous read ports supply the Reg_ReadData1/Reg_ReadData2 operands consumed by the stage-2 register.
- Sits between the execute stage output and the stage-1 decode/read logic.

Parameters:
- DATA_WIDTH, 32, width of every register and of the write/read data.
- ADDR_WIDTH, 5, register select width; depth is 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is a normal register.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-low: sampled on posedge clk, 0 = reset.
- S2_ALUOut  input  DATA_WIDTH  execute-stage result.
- S2_WriteSelect  input  ADDR_WIDTH  destination register from the stage-2 register.
- S2_WriteEnable  input  1  destination write request from the stage-2 register.
- S1_ReadSelect1  input  ADDR_WIDTH  read port 1 address.
- S1_ReadSelect2  input  ADDR_WIDTH  read port 2 address.
- Reg_ReadData1  output  DATA_WIDTH  read port 1 data (combinational).
- Reg_ReadData2  output  DATA_WIDTH  read port 2 data (combinational).
- S3_ALUOut  output  DATA_WIDTH  stage-3 registered result.
- S3_WriteSelect  output  ADDR_WIDTH  stage-3 registered destination.
- S3_WriteEnable  output  1  stage-3 registered write enable.

Behaviour:
- Reset (rst=0 at posedge):
  - S3_ALUOut=0, S3_WriteSelect=0, S3_WriteEnable=0.
  - All register-file entries cleared to 0 on the same edge.
  - Reset wins over any simultaneous write.
  - Reset mid-stream discards the in-flight stage-3 write.
- Stage 3: every non-reset posedge, S3_* <= S2_* unconditionally. No stall or flush input.
- Commit:
  - On posedge with rst=1 and S3_WriteEnable=1, regfile[S3_WriteSelect] <= S3_ALUOut.
  - Latency from S2 inputs to architectural state is 2 edges: edge 1 latches S3, edge 2 writes the register file.
- Zero register:
  - With ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0 regardless of bypass.
  - With ZERO_REG=0, address 0 behaves like any other register.
- Reads:
  - Purely combinational from the current regfile contents (plus bypass when enabled).
  - Both ports may address the same register; both return identical data.
- Write enable low: no entry changes, and S3_WriteSelect is ignored.
- Back-to-back writes to the same register: each commits in order, and the last one wins.
- All arithmetic is pass-through; no widening or truncation.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If S3_WriteEnable=1 and S3_WriteSelect equals a read select (and is not the zero register), that port returns S3_ALUOut in the same cycle (write-before-read).
  - Port 1 and port 2 are bypassed independently.
- Undefined:
  - Reads return the stored value.
  - The committing value becomes visible only after the commit edge.

Decomposition:
- Shared package (`pipeline_pkg`) holds:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - ZERO_REG_ADDR constant (= 0).
  - `wb_bundle_t` typedef grouping ALUOut, WriteSelect and WriteEnable for stage-to-stage passing.
- One natural sub-module, `regfile_2r1w`: storage array, reset clear, write port, two read ports and optional bypass.
- Top level adds the stage-3 register around `regfile_2r1w`.

Test Plan:
- Reset: hold rst=0 for 2 cycles after arbitrary writes -> S3_* = 0; reads of all 32 addresses return 0.
- Basic write: S2_ALUOut=0xDEADBEEF, S2_WriteSelect=5, S2_WriteEnable=1 for one cycle -> S3_ALUOut=0xDEADBEEF after edge 1; ReadSelect1=5 returns 0xDEADBEEF after edge 2 and not before (bypass undefined).
- Zero register: write 0x12345678 to address 0 -> reads of address 0 stay 0. With ZERO_REG=0 the same read returns 0x12345678.
- Enable low: S2_WriteEnable=0, S2_WriteSelect=7, S2_ALUOut=0xFFFFFFFF -> register 7 keeps its prior value 0x00000011.
- Bypass: with REGFILE_WRITE_BYPASS_EN, in the cycle S3 holds (sel=9, data=0xA5A5A5A5, we=1), both read ports on 9 return 0xA5A5A5A5. Without the macro they return the old value 0x0 until after the commit edge.
- Reset mid-operation: write to register 3 issued, rst=0 on the commit edge -> register 3 reads 0 and S3_WriteEnable=0.
